// File: rtl/oflow_core_seq_ctrl.sv
// oflow_core_seq_ctrl: frame sequencer issuing PE passes, bounded conflict-resolve rounds and write-back per frame
module oflow_core_seq_ctrl #(
  parameter int PE_NUM      = 24,
  parameter int BBOX_W      = 8,
  parameter int FRAME_W     = 8,
  parameter int HIST_W      = 3,
  parameter int CR_MAX_ITER = 4,
  parameter int PEC_W       = $clog2(PE_NUM+1),
  parameter int SET_W       = BBOX_W,
  parameter int ITER_W      = $clog2(CR_MAX_ITER+1)
) (
  input  logic               clk,
  input  logic               reset_N,
  input  logic               start,
  input  logic               abort,
  input  logic               new_frame,
  output logic               ready_new_frame,
  input  logic [BBOX_W-1:0]  num_of_bbox_in_frame,
  input  logic [HIST_W-1:0]  num_of_history_frames,
  input  logic               new_set_valid,
  output logic               ready_new_set,
  output logic               start_pe,
  output logic [PEC_W-1:0]   pe_bbox_count,
  input  logic               done_pe,
  output logic               start_cr,
  input  logic               done_cr,
  input  logic               cr_conflict,
  output logic               start_write,
  input  logic               done_write,
  output logic [FRAME_W-1:0] frame_num,
  output logic [SET_W-1:0]   num_of_sets,
  output logic [SET_W-1:0]   set_idx,
  output logic               frame_done,
  output logic               cr_overflow_err
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_SET, PE, CR, WRITE} state_t;
  // Wide enough to hold nbox + PE_NUM - 1 without overflow
  localparam int CW = (BBOX_W > PEC_W ? BBOX_W : PEC_W) + 1;
  localparam logic [CW-1:0] PE_C = CW'(PE_NUM);
  state_t state_q, state_d;
  logic [BBOX_W-1:0]  remain_q, remain_d;
  logic [PEC_W-1:0]   pe_bbox_count_q, pe_bbox_count_d;
  logic [SET_W-1:0]   num_of_sets_q, num_of_sets_d, set_idx_q, set_idx_d;
  logic [FRAME_W-1:0] frame_num_q, frame_num_d;
  logic [ITER_W-1:0]  cr_iter_q, cr_iter_d;
  logic start_pe_q, start_pe_d, start_cr_q, start_cr_d, start_write_q, start_write_d;
  logic frame_done_q, frame_done_d, err_q, err_d;
  logic [CW-1:0] sets_w, rem_w, take_w;
  assign sets_w = (CW'(num_of_bbox_in_frame) + PE_C - CW'(1)) / PE_C;
  assign rem_w  = CW'(remain_q);
  assign take_w = rem_w < PE_C ? rem_w : PE_C;
  always_comb begin
    state_d         = state_q;
    remain_d        = remain_q;
    pe_bbox_count_d = pe_bbox_count_q;
    num_of_sets_d   = num_of_sets_q;
    set_idx_d       = set_idx_q;
    frame_num_d     = frame_num_q;
    cr_iter_d       = cr_iter_q;
    err_d           = err_q;
    start_pe_d      = 1'b0;
    start_cr_d      = 1'b0;
    start_write_d   = 1'b0;
    frame_done_d    = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else if (start) begin
      frame_num_d = '0;
      err_d       = 1'b0;
      state_d     = LOAD;
    end else begin
      case (state_q)
        IDLE: state_d = new_frame ? LOAD : IDLE;
        LOAD: begin
          remain_d      = num_of_bbox_in_frame;
          num_of_sets_d = SET_W'(sets_w);
          set_idx_d     = '0;
          state_d       = (num_of_bbox_in_frame == '0) ? WRITE : WAIT_SET;
          start_write_d = (num_of_bbox_in_frame == '0);
        end
        WAIT_SET: if (new_set_valid) begin
          pe_bbox_count_d = PEC_W'(take_w);
          start_pe_d      = 1'b1;
          state_d         = PE;
        end
        // A done arriving alongside its own start pulse is stale and ignored
        PE: if (done_pe && !start_pe_q) begin
          remain_d  = remain_q - BBOX_W'(pe_bbox_count_q);
          set_idx_d = set_idx_q + SET_W'(1);
          if (set_idx_q + SET_W'(1) < num_of_sets_q) begin
            state_d = WAIT_SET;
          end else if (frame_num_q == '0 || num_of_history_frames == '0) begin
            state_d       = WRITE;
            start_write_d = 1'b1;
          end else begin
            state_d    = CR;
            cr_iter_d  = ITER_W'(1);
            start_cr_d = 1'b1;
          end
        end
        CR: if (done_cr && !start_cr_q) begin
          if (cr_conflict && cr_iter_q < ITER_W'(CR_MAX_ITER)) begin
            cr_iter_d  = cr_iter_q + ITER_W'(1);
            start_cr_d = 1'b1;
          end else begin
            err_d         = err_q | cr_conflict;
            state_d       = WRITE;
            start_write_d = 1'b1;
          end
        end
        WRITE: if (done_write && !start_write_q) begin
          frame_num_d  = frame_num_q + FRAME_W'(1);
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q         <= IDLE;
      remain_q        <= '0;
      pe_bbox_count_q <= '0;
      num_of_sets_q   <= '0;
      set_idx_q       <= '0;
      frame_num_q     <= '0;
      cr_iter_q       <= '0;
      err_q           <= 1'b0;
      start_pe_q      <= 1'b0;
      start_cr_q      <= 1'b0;
      start_write_q   <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      remain_q        <= remain_d;
      pe_bbox_count_q <= pe_bbox_count_d;
      num_of_sets_q   <= num_of_sets_d;
      set_idx_q       <= set_idx_d;
      frame_num_q     <= frame_num_d;
      cr_iter_q       <= cr_iter_d;
      err_q           <= err_d;
      start_pe_q      <= start_pe_d;
      start_cr_q      <= start_cr_d;
      start_write_q   <= start_write_d;
      frame_done_q    <= frame_done_d;
    end
  end
  assign ready_new_frame = (state_q == IDLE);
  assign ready_new_set   = (state_q == WAIT_SET);
  assign start_pe        = start_pe_q;
  assign start_cr        = start_cr_q;
  assign start_write     = start_write_q;
  assign frame_done      = frame_done_q;
  assign pe_bbox_count   = pe_bbox_count_q;
  assign num_of_sets     = num_of_sets_q;
  assign set_idx         = set_idx_q;
  assign frame_num       = frame_num_q;
  assign cr_overflow_err = err_q;
endmodule

// File: tb/tb_oflow_core_seq_ctrl.sv
// tb_oflow_core_seq_ctrl: directed frame sequences with hand-computed pulse counts and counters
module tb_oflow_core_seq_ctrl;
  localparam int PE_NUM = 24, BBOX_W = 8, FRAME_W = 8, HIST_W = 3, CR_MAX_ITER = 4;
  localparam int PEC_W = $clog2(PE_NUM+1);
  logic clk = 1'b0, reset_N, start, abort, new_frame, ready_new_frame;
  logic [BBOX_W-1:0] num_of_bbox_in_frame;
  logic [HIST_W-1:0] num_of_history_frames;
  logic new_set_valid, ready_new_set, start_pe, done_pe, start_cr, done_cr, cr_conflict;
  logic start_write, done_write, frame_done, cr_overflow_err;
  logic [PEC_W-1:0] pe_bbox_count;
  logic [FRAME_W-1:0] frame_num;
  logic [BBOX_W-1:0] num_of_sets, set_idx;
  int errors = 0, checks = 0;
  int n_pe, n_cr, n_wr, n_fd, lat, sidx0;
  int pe_cnt [8];
  bit saw_rns, ended;
  oflow_core_seq_ctrl #(.PE_NUM(PE_NUM), .BBOX_W(BBOX_W), .FRAME_W(FRAME_W),
    .HIST_W(HIST_W), .CR_MAX_ITER(CR_MAX_ITER)) dut (
    .clk(clk), .reset_N(reset_N), .start(start), .abort(abort), .new_frame(new_frame),
    .ready_new_frame(ready_new_frame), .num_of_bbox_in_frame(num_of_bbox_in_frame),
    .num_of_history_frames(num_of_history_frames), .new_set_valid(new_set_valid),
    .ready_new_set(ready_new_set), .start_pe(start_pe), .pe_bbox_count(pe_bbox_count),
    .done_pe(done_pe), .start_cr(start_cr), .done_cr(done_cr), .cr_conflict(cr_conflict),
    .start_write(start_write), .done_write(done_write), .frame_num(frame_num),
    .num_of_sets(num_of_sets), .set_idx(set_idx), .frame_done(frame_done),
    .cr_overflow_err(cr_overflow_err));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Runs one frame acting as DMA/PE/CR/MEM; rounds numbered <= ncflt report conflict; abort_at>0 aborts during that PE pass
  task automatic do_frame(input bit use_start, input int nbox, input int hist, input int ncflt, input int abort_at);
    int c;
    bit ppe, pcr, pwr, ab;
    n_pe = 0; n_cr = 0; n_wr = 0; n_fd = 0; lat = -1; sidx0 = -1; saw_rns = 0;
    ppe = 0; pcr = 0; pwr = 0; ab = 0; c = 0;
    if (!use_start) begin
      while (!ready_new_frame && c < 50) begin @(negedge clk); c++; end
      if (!ready_new_frame) chk("ready_new_frame_wait", 32'(ready_new_frame), 32'd1);
    end
    num_of_bbox_in_frame = BBOX_W'(nbox);
    num_of_history_frames = HIST_W'(hist);
    if (use_start) start = 1'b1; else new_frame = 1'b1;
    @(negedge clk);
    start = 1'b0; new_frame = 1'b0; c = 0;
    while (c < 400) begin
      c++;
      if (ab) begin abort = 1'b0; break; end
      if (ready_new_set) begin
        saw_rns = 1;
        if (lat < 0) begin lat = c; sidx0 = int'(set_idx); end
      end
      if (start_pe) begin
        if (n_pe < 8) pe_cnt[n_pe] = int'(pe_bbox_count);
        n_pe++;
      end
      if (start_cr) n_cr++;
      if (start_write) n_wr++;
      if (frame_done) begin n_fd++; break; end
      new_set_valid = ready_new_set;
      cr_conflict = (n_cr <= ncflt);
      done_cr = pcr;
      done_write = pwr;
      done_pe = ppe && !(abort_at == n_pe);
      if (ppe && abort_at == n_pe) begin abort = 1'b1; ab = 1; end
      ppe = start_pe; pcr = start_cr; pwr = start_write;
      @(negedge clk);
    end
    new_set_valid = 0; done_pe = 0; done_cr = 0; done_write = 0; cr_conflict = 0; abort = 0;
    ended = ab || (n_fd > 0);
    chk("frame_completed", 32'(ended), 32'd1);
  endtask
  initial begin
    reset_N = 0; start = 0; abort = 0; new_frame = 0; num_of_bbox_in_frame = '0;
    num_of_history_frames = '0; new_set_valid = 0; done_pe = 0; done_cr = 0;
    cr_conflict = 0; done_write = 0;
    #3;
    chk("rst_ready_new_frame", 32'(ready_new_frame), 32'd1);
    chk("rst_ready_new_set", 32'(ready_new_set), 32'd0);
    chk("rst_frame_num", 32'(frame_num), 32'd0);
    chk("rst_num_of_sets", 32'(num_of_sets), 32'd0);
    chk("rst_start_pe", 32'(start_pe), 32'd0);
    chk("rst_err", 32'(cr_overflow_err), 32'd0);
    @(negedge clk); reset_N = 1;
    @(negedge clk);
    // Frame 0, 50 boxes: sets of 24,24,2; history ignored on frame 0
    do_frame(1, 50, 2, 0, 0);
    chk("f0_n_pe", 32'(n_pe), 32'd3);
    chk("f0_cnt0", 32'(pe_cnt[0]), 32'd24);
    chk("f0_cnt1", 32'(pe_cnt[1]), 32'd24);
    chk("f0_cnt2", 32'(pe_cnt[2]), 32'd2);
    chk("f0_num_of_sets", 32'(num_of_sets), 32'd3);
    chk("f0_set_idx_end", 32'(set_idx), 32'd3);
    chk("f0_n_cr", 32'(n_cr), 32'd0);
    chk("f0_n_wr", 32'(n_wr), 32'd1);
    chk("f0_n_fd", 32'(n_fd), 32'd1);
    chk("f0_frame_num", 32'(frame_num), 32'd1);
    chk("f0_latency", 32'(lat), 32'd2);
    chk("f0_first_set_idx", 32'(sidx0), 32'd0);
    // Frame 1, two conflicting rounds then clean
    do_frame(0, 24, 2, 2, 0);
    chk("f1_n_pe", 32'(n_pe), 32'd1);
    chk("f1_cnt0", 32'(pe_cnt[0]), 32'd24);
    chk("f1_num_of_sets", 32'(num_of_sets), 32'd1);
    chk("f1_n_cr", 32'(n_cr), 32'd3);
    chk("f1_n_wr", 32'(n_wr), 32'd1);
    chk("f1_err", 32'(cr_overflow_err), 32'd0);
    chk("f1_frame_num", 32'(frame_num), 32'd2);
    // Always conflicting: capped at CR_MAX_ITER rounds, sticky error, write still issued
    do_frame(0, 24, 2, 100, 0);
    chk("ovf_n_cr", 32'(n_cr), 32'd4);
    chk("ovf_err", 32'(cr_overflow_err), 32'd1);
    chk("ovf_n_wr", 32'(n_wr), 32'd1);
    chk("ovf_frame_num", 32'(frame_num), 32'd3);
    // start clears frame_num and error; empty frame goes straight to write
    do_frame(1, 0, 2, 0, 0);
    chk("empty_n_pe", 32'(n_pe), 32'd0);
    chk("empty_saw_rns", 32'(saw_rns), 32'd0);
    chk("empty_n_wr", 32'(n_wr), 32'd1);
    chk("empty_err_cleared", 32'(cr_overflow_err), 32'd0);
    chk("empty_frame_num", 32'(frame_num), 32'd1);
    chk("empty_num_of_sets", 32'(num_of_sets), 32'd0);
    // Abort during second of three PE passes
    do_frame(0, 60, 0, 0, 2);
    chk("abort_idle", 32'(ready_new_frame), 32'd1);
    chk("abort_n_pe", 32'(n_pe), 32'd2);
    chk("abort_n_wr", 32'(n_wr), 32'd0);
    done_pe = 1;
    @(negedge clk);
    done_pe = 0;
    chk("late_done_idle", 32'(ready_new_frame), 32'd1);
    chk("late_done_no_write", 32'(start_write), 32'd0);
    chk("late_done_no_fd", 32'(frame_done), 32'd0);
    chk("abort_frame_num", 32'(frame_num), 32'd1);
    do_frame(0, 30, 0, 0, 0);
    chk("restart_set_idx", 32'(sidx0), 32'd0);
    chk("restart_n_pe", 32'(n_pe), 32'd2);
    chk("restart_cnt1", 32'(pe_cnt[1]), 32'd6);
    chk("restart_frame_num", 32'(frame_num), 32'd2);
    // frame_num wrap over 256 single-box frames
    do_frame(1, 1, 0, 0, 0);
    for (int i = 0; i < 254; i++) do_frame(0, 1, 0, 0, 0);
    chk("wrap_255", 32'(frame_num), 32'd255);
    do_frame(0, 1, 0, 0, 0);
    chk("wrap_0", 32'(frame_num), 32'd0);
    do_frame(0, 1, 0, 0, 0);
    chk("post_wrap_1", 32'(frame_num), 32'd1);
    // Asynchronous reset in the middle of WRITE
    num_of_bbox_in_frame = '0;
    new_frame = 1;
    @(negedge clk);
    new_frame = 0;
    for (int i = 0; i < 10 && !start_write; i++) @(negedge clk);
    chk("rstw_write_seen", 32'(start_write), 32'd1);
    #2 reset_N = 0;
    #1;
    chk("rstw_ready_new_frame", 32'(ready_new_frame), 32'd1);
    chk("rstw_start_write", 32'(start_write), 32'd0);
    chk("rstw_frame_num", 32'(frame_num), 32'd0);
    chk("rstw_pe_bbox_count", 32'(pe_bbox_count), 32'd0);
    chk("rstw_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk); reset_N = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
